flash_cmd_parser: RTL and testbench

Byte-level command parser between the USB receive/transmit byte streams and the `flash` programming engine in the bootloader; runs on `clock_02` alongside `flash`. Decodes ERASE, WRITE and PING commands from the host. Assembles 256-byte pages into the 2048-bit `wr_data` bus and drives the `erase_req`/`wr_req` handshakes. Returns one status byte per command.

---
 rtl/flash_cmd_pkg.sv | 29 ++
 rtl/idle_timer.sv | 28 ++
 rtl/flash_cmd_parser.sv | 174 +++++++++++++++++
 tb/tb_flash_cmd_parser.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_cmd_pkg.sv
// Shared constants and types for the flash command parser: command and
// status byte codes, default page size and idle limit, and the FSM state type.
package flash_cmd_pkg;

    localparam logic [7:0] CMD_ERASE = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_PING  = 8'h03;

    localparam logic [7:0] STS_ACK = 8'hA5;
    localparam logic [7:0] STS_NAK = 8'hEE;

    localparam int PAGE_BYTES_DEF     = 256;
    localparam int TIMEOUT_CYCLES_DEF = 1048576;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_GET_SECT   = 3'd1,
        ST_GET_DATA   = 3'd2,
        ST_ERASE_WAIT = 3'd3,
        ST_WRITE_WAIT = 3'd4,
        ST_RESP       = 3'd5
    } state_t;

    // Only 32 sectors exist, so the top three bits of a sector byte must be zero.
    function automatic logic sector_ok(input logic [7:0] b);
        return (b[7:5] == 3'b000);
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle timer. Counts cycles while enabled and not cleared; emits a
// one-cycle expire pulse on the cycle the count reaches LIMIT-1.
module idle_timer #(
    parameter int LIMIT = 1048576
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [W-1:0] r_cnt;

    assign o_expire = i_enable & ~i_clear & (r_cnt == W'(LIMIT - 1));

    // Idle counter: cleared on activity or when not enabled, saturates at expiry.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear || !i_enable) begin
            r_cnt <= '0;
        end else if (!o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/flash_cmd_parser.sv
// Byte-level host command parser feeding the flash programming engine.
// Decodes ERASE / WRITE / PING, assembles pages into wr_data, drives the
// erase/write request levels and returns one status byte per command.
// Optional build macro FLASH_CMD_TIMEOUT_EN adds an inter-byte idle timeout
// that NAKs a command whose argument bytes stop arriving.
module flash_cmd_parser
    import flash_cmd_pkg::*;
#(
    parameter int PAGE_BYTES = PAGE_BYTES_DEF
`ifdef FLASH_CMD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    erase_req,
    output logic [4:0]              s_num,
    input  logic                    erase_done,
    output logic                    wr_req,
    output logic [8*PAGE_BYTES-1:0] wr_data,
    input  logic                    wr_done
);

    // Handshakes: a byte moves on a rising edge where valid and ready are both
    // high; valid is never withdrawn by the sender before that edge.

    localparam int CW = $clog2(PAGE_BYTES) + 1;

    state_t                  r_state;
    state_t                  w_next;
    logic [CW-1:0]           r_cnt;
    logic [4:0]              r_s_num;
    logic [7:0]              r_tx_data;
    logic [8*PAGE_BYTES-1:0] r_wr_data;

    logic w_rx_fire;
    logic w_last_byte;
    logic w_in_get;
    logic w_timeout;

    assign w_rx_fire   = rx_valid & rx_ready;
    assign w_last_byte = (r_cnt == CW'(PAGE_BYTES - 1));
    assign w_in_get    = (r_state == ST_GET_SECT) || (r_state == ST_GET_DATA);

`ifdef FLASH_CMD_TIMEOUT_EN
    idle_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .i_clock (clock),
        .i_reset (reset),
        .i_clear (w_rx_fire | ~w_in_get),
        .i_enable(w_in_get),
        .o_expire(w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode from the accepted byte, done pulses and host accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    case (rx_data)
                        CMD_ERASE: w_next = ST_GET_SECT;
                        CMD_WRITE: w_next = ST_GET_DATA;
                        default:   w_next = ST_RESP;
                    endcase
                end
            end
            ST_GET_SECT: begin
                if (w_rx_fire) begin
                    w_next = sector_ok(rx_data) ? ST_ERASE_WAIT : ST_RESP;
                end else if (w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_GET_DATA: begin
                if (w_rx_fire) begin
                    if (w_last_byte) begin
                        w_next = ST_WRITE_WAIT;
                    end
                end else if (w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            ST_ERASE_WAIT: if (erase_done) w_next = ST_RESP;
            ST_WRITE_WAIT: if (wr_done)    w_next = ST_RESP;
            ST_RESP:       if (tx_ready)   w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs; all held low while reset is asserted.
    always_comb begin
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        erase_req = 1'b0;
        wr_req    = 1'b0;
        if (!reset) begin
            rx_ready  = (r_state == ST_IDLE) || w_in_get;
            tx_valid  = (r_state == ST_RESP);
            erase_req = (r_state == ST_ERASE_WAIT);
            wr_req    = (r_state == ST_WRITE_WAIT);
        end
    end

    // Datapath: byte counter, sector latch, page assembly and status byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_s_num   <= '0;
            r_tx_data <= 8'h00;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_fire) begin
                        r_cnt <= '0;
                        if (rx_data == CMD_PING) begin
                            r_tx_data <= STS_ACK;
                        end else if (rx_data != CMD_ERASE && rx_data != CMD_WRITE) begin
                            r_tx_data <= STS_NAK;
                        end
                    end
                end
                ST_GET_SECT: begin
                    if (w_rx_fire) begin
                        if (sector_ok(rx_data)) begin
                            r_s_num <= rx_data[4:0];
                        end else begin
                            r_tx_data <= STS_NAK;
                        end
                    end else if (w_timeout) begin
                        r_tx_data <= STS_NAK;
                    end
                end
                ST_GET_DATA: begin
                    if (w_rx_fire) begin
                        r_wr_data[int'(r_cnt)*8 +: 8] <= rx_data;
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_timeout) begin
                        r_tx_data <= STS_NAK;
                    end
                end
                ST_ERASE_WAIT: if (erase_done) r_tx_data <= STS_ACK;
                ST_WRITE_WAIT: if (wr_done)    r_tx_data <= STS_ACK;
                default: ;
            endcase
        end
    end

    assign tx_data = r_tx_data;
    assign s_num   = r_s_num;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_flash_cmd_parser.sv
// Testbench for flash_cmd_parser: directed literal cases plus a randomized
// command stream scored against a transaction-level model of the protocol.
module tb_flash_cmd_parser;
    import flash_cmd_pkg::*;

    localparam int PB = 256;

    // ---------------- clock / reset ----------------
    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic            rx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready = 1'b1;
    logic            erase_req;
    logic [4:0]      s_num;
    logic            erase_done = 1'b0;
    logic            wr_req;
    logic [8*PB-1:0] wr_data;
    logic            wr_done = 1'b0;

    always #5 clock = ~clock;

`ifdef FLASH_CMD_TIMEOUT_EN
    flash_cmd_parser #(.PAGE_BYTES(PB), .TIMEOUT_CYCLES(64)) dut (
`else
    flash_cmd_parser #(.PAGE_BYTES(PB)) dut (
`endif
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .erase_req(erase_req), .s_num(s_num), .erase_done(erase_done),
        .wr_req(wr_req), .wr_data(wr_data), .wr_done(wr_done)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]      exp_q[$];
    logic [4:0]      exp_sect_q[$];
    logic [8*PB-1:0] exp_page_q[$];

    bit rand_ready = 1'b0;
    bit stray_en   = 1'b0;
    int done_delay = 4;
    int n_tx = 0;
    int n_erase_rise = 0;
    int n_wr_rise = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_page(input string nm, input logic [8*PB-1:0] act, input logic [8*PB-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            for (int i = 0; i < PB; i++) begin
                if (act[i*8 +: 8] !== exp[i*8 +: 8]) begin
                    $display("FAIL %s: byte %0d got 0x%0h expected 0x%0h at %0t",
                             nm, i, act[i*8 +: 8], exp[i*8 +: 8], $time);
                    break;
                end
            end
        end
    endtask

    // ---------------- compare process + host/flash responders ----------------
    logic            prev_erase = 1'b0;
    logic            prev_wr = 1'b0;
    logic [4:0]      prev_snum = '0;
    logic [8*PB-1:0] prev_page = '0;
    bit              hold_pend = 1'b0;
    logic [7:0]      hold_data = '0;
    int e_cnt = 0, e_lim = 0, w_cnt = 0, w_lim = 0;

    // Every falling edge: check outputs, then pick tx_ready and done pulses for
    // the coming rising edge.
    always @(negedge clock) begin
        if (reset) begin
            hold_pend  = 1'b0;
            prev_erase = 1'b0;
            prev_wr    = 1'b0;
            e_cnt      = 0;
            w_cnt      = 0;
            erase_done = 1'b0;
            wr_done    = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("tx_hold_data", {24'd0, tx_data}, {24'd0, hold_data});
            end
            if (erase_req && wr_req) chk("req_exclusive", 32'd1, 32'd0);
            if (erase_req && !prev_erase) begin
                n_erase_rise++;
                if (exp_sect_q.size() == 0) chk("erase_unexpected", 32'd1, 32'd0);
                else chk("erase_sector", {27'd0, s_num}, {27'd0, exp_sect_q.pop_front()});
            end else if (erase_req) begin
                chk("s_num_stable", {27'd0, s_num}, {27'd0, prev_snum});
            end
            if (wr_req && !prev_wr) begin
                n_wr_rise++;
                if (exp_page_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                else chk_page("wr_page", wr_data, exp_page_q.pop_front());
            end else if (wr_req) begin
                chk_page("wr_data_stable", wr_data, prev_page);
            end
            if (tx_valid || erase_req || wr_req) chk("rx_ready_busy", {31'd0, rx_ready}, 32'd0);

            tx_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            hold_pend = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (tx_valid && tx_ready) begin
                n_tx++;
                if (exp_q.size() == 0) chk("tx_unexpected", {24'd0, tx_data}, 32'h100);
                else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end

            if (erase_req) begin
                if (e_cnt == 0) e_lim = done_delay;
                e_cnt++;
                erase_done = (e_cnt == e_lim);
            end else begin
                e_cnt = 0;
                erase_done = stray_en && ($urandom_range(0, 7) == 0);
            end
            if (wr_req) begin
                if (w_cnt == 0) w_lim = done_delay;
                w_cnt++;
                wr_done = (w_cnt == w_lim);
            end else begin
                w_cnt = 0;
                wr_done = stray_en && ($urandom_range(0, 7) == 0);
            end

            prev_erase = erase_req;
            prev_wr    = wr_req;
            prev_snum  = s_num;
            prev_page  = wr_data;
        end
    end

    // ---------------- driver tasks ----------------
    // Offer one byte from a falling edge; return on the falling edge after the
    // rising edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (!rx_ready) begin
            chk("rx_accept_timeout", 32'd0, 32'd1);
            rx_valid = 1'b0;
            return;
        end
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic gap(input int mx);
        repeat ($urandom_range(0, mx)) @(negedge clock);
    endtask

    // Model: predict the status byte and any request payload from the command
    // bytes alone, then send them.
    task automatic send_cmd(input logic [7:0] code, input logic [7:0] arg,
                            input int gap_max, input bit seq_page);
        logic [8*PB-1:0] page;
        page = '0;
        if (code == CMD_PING) begin
            exp_q.push_back(8'hA5);
        end else if (code == CMD_ERASE) begin
            if (arg < 8'd32) begin
                exp_sect_q.push_back(arg[4:0]);
                exp_q.push_back(8'hA5);
            end else begin
                exp_q.push_back(8'hEE);
            end
        end else if (code == CMD_WRITE) begin
            for (int i = 0; i < PB; i++) page[i*8 +: 8] = seq_page ? i[7:0] : 8'($urandom);
            exp_page_q.push_back(page);
            exp_q.push_back(8'hA5);
        end else begin
            exp_q.push_back(8'hEE);
        end
        send_byte(code);
        if (code == CMD_ERASE) begin
            gap(gap_max);
            send_byte(arg);
        end else if (code == CMD_WRITE) begin
            for (int i = 0; i < PB; i++) begin
                gap(gap_max);
                send_byte(page[i*8 +: 8]);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_valid || erase_req || wr_req) && n < 5000) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", exp_q.size(), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int before_tx, before_wr, before_er;
        logic [7:0] code;

        // Reset values.
        repeat (2) @(negedge clock);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
        chk("rst_erase_req", {31'd0, erase_req}, 32'd0);
        chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
        chk("rst_s_num", {27'd0, s_num}, 32'd0);
        chk("rst_wr_data_zero", {31'd0, (wr_data == '0)}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

        // PING: status the cycle after the command byte, one cycle long.
        send_cmd(CMD_PING, 8'h00, 0, 1'b0);
        chk("ping_tx_valid", {31'd0, tx_valid}, 32'd1);
        chk("ping_tx_data", {24'd0, tx_data}, 32'hA5);
        chk("ping_rx_ready_low", {31'd0, rx_ready}, 32'd0);
        @(negedge clock);
        chk("ping_one_cycle", {31'd0, tx_valid}, 32'd0);
        chk("ping_no_req", {30'd0, erase_req, wr_req}, 32'd0);

        // ERASE sector 4, done 20 cycles after the request.
        done_delay = 20;
        send_cmd(CMD_ERASE, 8'h04, 0, 1'b0);
        chk("erase_rise", {31'd0, erase_req}, 32'd1);
        chk("erase_s_num", {27'd0, s_num}, 32'd4);
        n = 0;
        while (erase_req && n < 200) begin
            n++;
            @(negedge clock);
        end
        chk("erase_len", n, 32'd20);
        chk("erase_ack_valid", {31'd0, tx_valid}, 32'd1);
        chk("erase_ack_data", {24'd0, tx_data}, 32'hA5);
        drain();

        // WRITE 0x00..0xFF back-to-back.
        done_delay = 5;
        send_cmd(CMD_WRITE, 8'h00, 0, 1'b1);
        chk("wr_rise", {31'd0, wr_req}, 32'd1);
        chk("wr_first_byte", {24'd0, wr_data[7:0]}, 32'h00);
        chk("wr_last_byte", {24'd0, wr_data[2047:2040]}, 32'hFF);
        drain();

        // Bad sector and unknown code are NAKed without any request.
        before_er = n_erase_rise;
        send_cmd(CMD_ERASE, 8'h25, 0, 1'b0);
        chk("bad_sect_valid", {31'd0, tx_valid}, 32'd1);
        chk("bad_sect_nak", {24'd0, tx_data}, 32'hEE);
        drain();
        send_cmd(8'h7F, 8'h00, 0, 1'b0);
        chk("unknown_nak", {24'd0, tx_data}, 32'hEE);
        drain();
        chk("nak_no_erase", n_erase_rise, before_er);

        // Reset after 100 page bytes, then PING.
        before_tx = n_tx;
        before_wr = n_wr_rise;
        send_byte(CMD_WRITE);
        for (int i = 0; i < 100; i++) send_byte(8'($urandom));
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("midrst_wr_data_zero", {31'd0, (wr_data == '0)}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_idle", {31'd0, rx_ready}, 32'd1);
        send_cmd(CMD_PING, 8'h00, 0, 1'b0);
        drain();
        chk("midrst_one_status", n_tx - before_tx, 32'd1);
        chk("midrst_no_wr", n_wr_rise, before_wr);

        // Randomized command stream with host back-pressure and stray done pulses.
        rand_ready = 1'b1;
        stray_en   = 1'b1;
        for (int k = 0; k < 40; k++) begin
            done_delay = $urandom_range(1, 10);
            case ($urandom_range(0, 9))
                0, 1:    send_cmd(CMD_PING, 8'h00, 2, 1'b0);
                2, 3, 8: send_cmd(CMD_ERASE, 8'($urandom_range(0, 31)), 2, 1'b0);
                4:       send_cmd(CMD_ERASE, 8'($urandom_range(32, 255)), 2, 1'b0);
                5, 6:    send_cmd(CMD_WRITE, 8'h00, 1, 1'b0);
                default: begin
                    code = 8'($urandom_range(4, 255));
                    send_cmd(code, 8'h00, 2, 1'b0);
                end
            endcase
            gap(3);
        end
        drain();
        stray_en   = 1'b0;
        rand_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("left_sectors", exp_sect_q.size(), 32'd0);
        chk("left_pages", exp_page_q.size(), 32'd0);

`ifdef FLASH_CMD_TIMEOUT_EN
        // Stall a WRITE after 10 bytes: NAK after 64 idle cycles.
        before_wr = n_wr_rise;
        exp_q.push_back(8'hEE);
        send_byte(CMD_WRITE);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        n = 0;
        while (!tx_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("timeout_latency", n, 32'd64);
        chk("timeout_nak", {24'd0, tx_data}, 32'hEE);
        @(negedge clock);
        chk("timeout_idle", {31'd0, rx_ready}, 32'd1);
        chk("timeout_no_wr", n_wr_rise, before_wr);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
